// File: rtl/aes_stream_wrapper.sv
// -----------------------------------------------------------------------------
// aes_stream_wrapper
//
// Word-serial front/back end for a purely combinational AES cipher core.
// Plaintext and key words arrive on 32-bit valid/ready streams and are shifted
// into registers that drive the core's in/key buses. After a programmable
// settle time the core's output is captured and streamed out as four 32-bit
// ciphertext words. Input and output phases never overlap.
//
// Parameters
//   Nk          key length in 32-bit words (4, 6 or 8)
//   CIPHER_LAT  cycles from block launch to ciphertext capture (>= 1)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   key_valid/key_ready/key_data  key word stream, first word = key MSW
//   in_valid/in_ready/in_data     plaintext stream, first word = block[127:96]
//   cipher_in, cipher_key       registered block/key driven onto the core
//   cipher_out                  combinational core result
//   out_valid/out_ready/out_data/out_last  ciphertext stream, 4 words
//   key_loaded                  a complete key is held
//   busy                        block in flight (waiting or draining)
// -----------------------------------------------------------------------------
module aes_stream_wrapper #(
    parameter int Nk         = 4,
    parameter int CIPHER_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [31:0]      key_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [127:0]     cipher_in,
    output logic [Nk*32-1:0] cipher_key,
    input  logic [127:0]     cipher_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             key_loaded,
    output logic             busy
);

    localparam int KCW = (Nk > 1) ? $clog2(Nk) : 1;
    localparam int LCW = $clog2(CIPHER_LAT + 1);
    localparam logic [KCW-1:0] KEY_LAST = KCW'(Nk - 1);
    localparam logic [LCW-1:0] LAT_DONE = LCW'(CIPHER_LAT);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WAIT    = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t            r_state;
    logic [Nk*32-1:0]  r_key;
    logic [127:0]      r_blk;
    logic [127:0]      r_ct;
    logic [KCW-1:0]    r_key_cnt;
    logic [1:0]        r_blk_cnt;
    logic [LCW-1:0]    r_lat_cnt;
    logic [1:0]        r_idx;
    logic              r_key_loaded;

    logic              w_key_hs;
    logic              w_in_hs;
    logic              w_out_hs;

    // A key may only start between blocks; a key word in flight always wins
    // over plaintext, hence the combinational key_valid term in in_ready.
    assign key_ready  = (r_state == S_COLLECT) && (r_blk_cnt == 2'd0);
    assign in_ready   = (r_state == S_COLLECT) && r_key_loaded &&
                        (r_key_cnt == '0) && !key_valid;

    assign w_key_hs   = key_valid && key_ready;
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;

    assign cipher_in  = r_blk;
    assign cipher_key = r_key;
    assign key_loaded = r_key_loaded;
    assign busy       = (r_state != S_COLLECT);

    // The ciphertext register shifts left on each accepted word, so the
    // current word always sits in the top lane and the register is empty
    // once the block has drained.
    assign out_valid  = (r_state == S_DRAIN);
    assign out_data   = r_ct[127:96];
    assign out_last   = (r_state == S_DRAIN) && (r_idx == 2'd3);

    // NOTE: every state element uses non-blocking assignment so all registers
    // update together on the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide data registers are reset too, so a reset mid-block
            // leaves nothing of the old key, block or ciphertext on the buses.
            r_state      <= S_COLLECT;
            r_key        <= '0;
            r_blk        <= '0;
            r_ct         <= '0;
            r_key_cnt    <= '0;
            r_blk_cnt    <= 2'd0;
            r_lat_cnt    <= '0;
            r_idx        <= 2'd0;
            r_key_loaded <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_key_hs) begin
                        r_key <= {r_key[Nk*32-33:0], key_data};
                        if (r_key_cnt == KEY_LAST) begin
                            r_key_cnt    <= '0;
                            r_key_loaded <= 1'b1;
                        end else begin
                            r_key_cnt <= r_key_cnt + KCW'(1);
                            // The first word of a new key invalidates the old one.
                            if (r_key_cnt == '0) begin
                                r_key_loaded <= 1'b0;
                            end
                        end
                    end else if (w_in_hs) begin
                        r_blk <= {r_blk[95:0], in_data};
                        if (r_blk_cnt == 2'd3) begin
                            r_blk_cnt <= 2'd0;
                            r_lat_cnt <= LCW'(1);
                            r_state   <= S_WAIT;
                        end else begin
                            r_blk_cnt <= r_blk_cnt + 2'd1;
                        end
                    end
                end

                S_WAIT: begin
                    // cipher_in/cipher_key are frozen here, covering the
                    // multicycle path through the core.
                    if (r_lat_cnt == LAT_DONE) begin
                        r_ct      <= cipher_out;
                        r_lat_cnt <= '0;
                        r_idx     <= 2'd0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LCW'(1);
                    end
                end

                S_DRAIN: begin
                    if (w_out_hs) begin
                        r_ct <= {r_ct[95:0], 32'h0};
                        if (r_idx == 2'd3) begin
                            r_idx   <= 2'd0;
                            r_state <= S_COLLECT;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end

                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_wrapper.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_wrapper
//
// Self-checking bench for aes_stream_wrapper. The combinational AES core is
// modelled here: it presents a poison value on cipher_out until its inputs
// have been stable for CIPHER_LAT-1 edges, then the true AES result computed
// by a behavioural FIPS-197 cipher. A table of known-answer vectors runs
// first, followed by hand-written gating/reset sequences and randomized
// blocks with random output back-pressure.
// -----------------------------------------------------------------------------
module tb_aes_stream_wrapper;

    localparam int NK  = 4;
    localparam int LAT = 2;
    localparam int NR  = NK + 6;
    localparam logic [127:0] POISON = 128'hdeadbeef_0badf00d_feedface_c0ffee00;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              key_valid;
    logic              key_ready;
    logic [31:0]       key_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [127:0]      cipher_in;
    logic [NK*32-1:0]  cipher_key;
    logic [127:0]      cipher_out;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_last;
    logic              key_loaded;
    logic              busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    aes_stream_wrapper #(.Nk(NK), .CIPHER_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_data   (key_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cipher_in  (cipher_in),
        .cipher_key (cipher_key),
        .cipher_out (cipher_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .key_loaded (key_loaded),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- AES model
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                      rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                             input logic [NK*32-1:0] key);
        logic [31:0]  w [4*(NR+1)];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < NK; i++) w[i] = key[NK*32-1-32*i -: 32];
        for (int i = NK; i < 4*(NR+1); i++) begin
            tmp = w[i-1];
            if (i % NK == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (NK > 6 && i % NK == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-NK] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= NR; r++) begin
            if (r > 0) begin
                // byte i is row i%4, column i/4; row r rotates left by r
                for (int i = 0; i < 16; i++)
                    t[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
                if (r < NR) begin
                    for (int c = 0; c < 4; c++) begin
                        s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                        s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                        s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                        s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                    end
                end else begin
                    for (int i = 0; i < 16; i++) s[i] = t[i];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    s[4*c+b] = s[4*c+b] ^ w[4*r+c][31-8*b -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // Core model: result only settles after the inputs have been stable.
    logic [127:0]     core_last_in  = '0;
    logic [NK*32-1:0] core_last_key = '0;
    int               core_age      = 0;
    initial cipher_out = POISON;

    always @(posedge clk) begin
        #1;
        if (cipher_in !== core_last_in || cipher_key !== core_last_key) begin
            core_last_in  = cipher_in;
            core_last_key = cipher_key;
            core_age      = 0;
            cipher_out    = POISON;
        end else if (core_age < 1000) begin
            core_age++;
        end
        if (core_age == LAT - 1) cipher_out = aes_enc(cipher_in, cipher_key);
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cipher_in"}, cipher_in, '0);
        check({tag, "_cipher_key"}, cipher_key, '0);
        check({tag, "_ctl"}, {out_valid, out_last, out_data, busy, key_loaded}, '0);
    endtask

    function automatic logic [NK*32-1:0] rand_key();
        logic [NK*32-1:0] k;
        for (int i = 0; i < NK; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // All stimulus tasks start and end on a falling edge; inputs are sampled
    // 1 time unit before the rising edge.
    task automatic send_key_words(input logic [NK*32-1:0] k, input int from);
        for (int i = from; i < NK; i++) begin
            bit done;
            done      = 1'b0;
            key_valid = 1'b1;
            key_data  = k[NK*32-1-32*i -: 32];
            for (int t = 0; t < 40 && !done; t++) begin
                #4;
                done = key_ready;
                @(negedge clk);
            end
            if (!done) check("key_handshake_timeout", 0, 1);
        end
        key_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] pt, input int from, input int to,
                              output int first_cyc);
        first_cyc = -1;
        for (int i = from; i <= to; i++) begin
            bit done;
            done     = 1'b0;
            in_valid = 1'b1;
            in_data  = pt[127-32*i -: 32];
            for (int t = 0; t < 40 && !done; t++) begin
                #4;
                done = in_ready;
                if (done && first_cyc < 0) first_cyc = cyc;
                @(negedge clk);
            end
            if (!done) check("in_handshake_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    // Collects nwords output words; junk is offered on both input streams
    // throughout and must never be accepted.
    task automatic recv_block(input bit bp, input int nwords, input int first_in,
                              input logic [127:0] exp, input string tag);
        logic [127:0] got;
        logic [31:0]  prev_data;
        logic         prev_last;
        bit           stalled;
        int           w;
        int           first_out;
        int           t;
        got = '0; prev_data = '0; prev_last = 1'b0; stalled = 1'b0;
        w = 0; first_out = -1; t = 0;
        key_valid = 1'b1; key_data = 32'hbad0_0001;
        in_valid  = 1'b1; in_data  = 32'hbad0_0002;
        while (w < nwords && t < 200) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            check("ready_while_busy", {key_ready, in_ready, busy}, 3'b001);
            if (out_valid) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    if (first_in >= 0) check("first_out_latency", first_out - first_in, 4 + LAT);
                end
                if (stalled) check("stall_hold", {out_data, out_last}, {prev_data, prev_last});
                if (out_ready) begin
                    got = {got[95:0], out_data};
                    check("out_last", out_last, (w == 3));
                    w++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    prev_data = out_data;
                    prev_last = out_last;
                end
            end
            @(negedge clk);
            t++;
        end
        key_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (w < nwords) check("out_timeout", 0, 1);
        if (nwords == 4) begin
            check(tag, got, exp);
            #4;
            check("idle_after_last", {out_valid, busy}, 2'b00);
            @(negedge clk);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        in_valid = 1'b1;
        in_data  = 32'hbad0_0003;
        for (int i = 0; i < n; i++) begin
            #4;
            check(tag, {out_valid, in_ready, key_loaded, busy}, 4'b0000);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        bit               load_key;
        logic [NK*32-1:0] key;
        logic [127:0]     pt;
        logic [127:0]     ct;
        bit               bp;
    } vec_t;

    localparam logic [127:0] KEY_C1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d_02dc09fb_dc118597_196a0b32;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NK*32-1:0] cur_key;
        logic [NK*32-1:0] k3;
        logic [127:0]     pt;
        int               fc;

        rst_n = 1'b0; key_valid = 1'b0; key_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        build_sbox();

        vecs[0] = '{load_key: 1'b1, key: KEY_C1, pt: PT_C1, ct: CT_C1, bp: 1'b0};
        vecs[1] = '{load_key: 1'b0, key: KEY_C1, pt: PT_B,
                    ct: aes_enc(PT_B, KEY_C1), bp: 1'b0};
        vecs[2] = '{load_key: 1'b1, key: KEY_B, pt: PT_B, ct: CT_B, bp: 1'b0};
        vecs[3] = '{load_key: 1'b0, key: KEY_B, pt: PT_C1,
                    ct: aes_enc(PT_C1, KEY_B), bp: 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        check("reset_ready", {key_ready, in_ready}, 2'b10);
        rst_n = 1'b1;
        @(negedge clk);

        // Plaintext before any key is never accepted
        in_valid = 1'b1;
        in_data  = 32'hbad0_0004;
        for (int i = 0; i < 3; i++) begin
            #4;
            check("in_ready_no_key", in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Known-answer table, including key reuse and back-pressure
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].load_key) begin
                send_key_words(vecs[v].key, 0);
                check("key_loaded", key_loaded, 1'b1);
                check("cipher_key", cipher_key, vecs[v].key);
            end
            send_block(vecs[v].pt, 0, 3, fc);
            recv_block(vecs[v].bp, 4, fc, vecs[v].ct, $sformatf("ct_vec%0d", v));
        end
        cur_key = KEY_B;

        // key_valid and in_valid together with a key loaded: key wins
        k3        = rand_key();
        key_valid = 1'b1;
        key_data  = k3[NK*32-1 -: 32];
        in_valid  = 1'b1;
        in_data   = 32'hbad0_0005;
        #4;
        check("prio_ready", {key_ready, in_ready}, 2'b10);
        @(negedge clk);
        key_valid = 1'b0;
        in_valid  = 1'b0;
        check("prio_key_loaded_cleared", key_loaded, 1'b0);
        check("prio_block_untouched", cipher_in, PT_C1);
        send_key_words(k3, 1);
        check("prio_key_loaded", key_loaded, 1'b1);
        check("prio_cipher_key", cipher_key, k3);
        cur_key = k3;

        // A key word offered mid-block is refused and corrupts nothing
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 0, 1, fc);
        key_valid = 1'b1;
        key_data  = 32'hbad0_0006;
        #4;
        check("key_ready_blk2", key_ready, 1'b0);
        @(negedge clk);
        key_valid = 1'b0;
        send_block(pt, 2, 3, fc);
        recv_block(1'b0, 4, -1, aes_enc(pt, cur_key), "ct_blk2_key_refused");

        // Randomized blocks with occasional key reloads and back-pressure
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                cur_key = rand_key();
                send_key_words(cur_key, 0);
            end
            pt = {$urandom, $urandom, $urandom, $urandom};
            send_block(pt, 0, 3, fc);
            recv_block(1'b1, 4, fc, aes_enc(pt, cur_key), $sformatf("ct_rand%0d", r));
        end

        // Reset during WAIT
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 0, 3, fc);
        check("in_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle_after_rst_wait", 6);

        // Reset in the middle of DRAIN
        send_key_words(KEY_C1, 0);
        send_block(PT_C1, 0, 3, fc);
        recv_block(1'b0, 2, fc, '0, "");
        check("mid_drain", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_drain");
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle_after_rst_drain", 6);

        // Full reload reproduces the known answer
        send_key_words(KEY_C1, 0);
        send_block(PT_C1, 0, 3, fc);
        recv_block(1'b0, 4, fc, CT_C1, "ct_reload");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
